// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one burst memory read channel between
// the I-cache (requester 0) and the D-cache (requester 1).
module mem_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_EN      = 1,
    parameter int MAX_BEATS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  from_ic_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] from_ic_rd_req_addr,
    output logic                  to_ic_rd_req_ready,
    output logic                  to_ic_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] to_ic_rd_rsp_data,
    output logic                  to_ic_rd_rsp_last,
    input  logic                  from_ic_rd_rsp_ready,
    input  logic                  from_dc_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] from_dc_rd_req_addr,
    output logic                  to_dc_rd_req_ready,
    output logic                  to_dc_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] to_dc_rd_rsp_data,
    output logic                  to_dc_rd_rsp_last,
    input  logic                  from_dc_rd_rsp_ready,
    output logic                  to_mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready,
    output logic                  burst_overrun
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  beat_acc;

    // Channel routing: only the granted requester sees the memory side
    always_comb begin
        to_ic_rd_req_ready  = 1'b0;
        to_ic_rd_rsp_valid  = 1'b0;
        to_ic_rd_rsp_data   = '0;
        to_ic_rd_rsp_last   = 1'b0;
        to_dc_rd_req_ready  = 1'b0;
        to_dc_rd_rsp_valid  = 1'b0;
        to_dc_rd_rsp_data   = '0;
        to_dc_rd_rsp_last   = 1'b0;
        to_mem_rd_req_valid = 1'b0;
        to_mem_rd_req_addr  = '0;
        to_mem_rd_rsp_ready = 1'b0;
        unique case (1'b1)
            state_q[1]: begin
                to_mem_rd_req_valid = 1'b1;
                to_mem_rd_req_addr  = addr_q;
                to_ic_rd_req_ready  = !gnt_q && from_mem_rd_req_ready;
                to_dc_rd_req_ready  = gnt_q && from_mem_rd_req_ready;
            end
            state_q[2]: begin
                if (gnt_q) begin
                    to_dc_rd_rsp_valid  = from_mem_rd_rsp_valid;
                    to_dc_rd_rsp_data   = from_mem_rd_rsp_data;
                    to_dc_rd_rsp_last   = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready = from_dc_rd_rsp_ready;
                end else begin
                    to_ic_rd_rsp_valid  = from_mem_rd_rsp_valid;
                    to_ic_rd_rsp_data   = from_mem_rd_rsp_data;
                    to_ic_rd_rsp_last   = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready = from_ic_rd_rsp_ready;
                end
            end
            default: ;
        endcase
        beat_acc = state_q[2] && from_mem_rd_rsp_valid
                   && to_mem_rd_rsp_ready;
    end

    // Next state: arbitrate in IDLE, hold the grant until the last beat
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = overrun_q;
        case (state_q)
            IDLE: begin
                if (from_ic_rd_req_valid || from_dc_rd_req_valid) begin
                    if (from_ic_rd_req_valid && from_dc_rd_req_valid)
                        gnt_d = (RR_EN != 0) ? rr_ptr_q : 1'b0;
                    else
                        gnt_d = from_dc_rd_req_valid;
                    addr_d  = gnt_d ? from_dc_rd_req_addr
                                    : from_ic_rd_req_addr;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (from_mem_rd_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (beat_acc) begin
                    if (beat_cnt_q != CW'(MAX_BEATS))
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    if (!from_mem_rd_rsp_last
                        && beat_cnt_q == CW'(MAX_BEATS - 1))
                        overrun_d = 1'b1;
                    if (from_mem_rd_rsp_last) begin
                        state_d = IDLE;
                        if (RR_EN != 0)
                            rr_ptr_d = ~gnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign burst_overrun = overrun_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: scoreboard bench for mem_rd_arbiter,
// round-robin instance plus a fixed-priority instance on shared inputs.
module tb_mem_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_valid = 1'b0, dc_valid = 1'b0;
    logic [31:0] ic_addr = '0, dc_addr = '0;
    logic        ic_rsp_ready = 1'b1, dc_rsp_ready = 1'b1;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_last = 1'b0;

    logic        ic_req_ready, ic_rsp_valid, ic_rsp_last;
    logic [31:0] ic_rsp_data;
    logic        dc_req_ready, dc_rsp_valid, dc_rsp_last;
    logic [31:0] dc_rsp_data;
    logic        mem_req_valid, mem_rsp_ready, overrun;
    logic [31:0] mem_req_addr;

    logic        fp_ic_req_ready, fp_ic_rsp_valid, fp_ic_rsp_last;
    logic [31:0] fp_ic_rsp_data;
    logic        fp_dc_req_ready, fp_dc_rsp_valid, fp_dc_rsp_last;
    logic [31:0] fp_dc_rsp_data;
    logic        fp_mem_req_valid, fp_mem_rsp_ready, fp_overrun;
    logic [31:0] fp_mem_req_addr;

    always #5 clk = ~clk;

    mem_rd_arbiter #(.RR_EN(1), .MAX_BEATS(8)) u_dut (
        .clk(clk), .rst(rst),
        .from_ic_rd_req_valid(ic_valid), .from_ic_rd_req_addr(ic_addr),
        .to_ic_rd_req_ready(ic_req_ready), .to_ic_rd_rsp_valid(ic_rsp_valid),
        .to_ic_rd_rsp_data(ic_rsp_data), .to_ic_rd_rsp_last(ic_rsp_last),
        .from_ic_rd_rsp_ready(ic_rsp_ready),
        .from_dc_rd_req_valid(dc_valid), .from_dc_rd_req_addr(dc_addr),
        .to_dc_rd_req_ready(dc_req_ready), .to_dc_rd_rsp_valid(dc_rsp_valid),
        .to_dc_rd_rsp_data(dc_rsp_data), .to_dc_rd_rsp_last(dc_rsp_last),
        .from_dc_rd_rsp_ready(dc_rsp_ready),
        .to_mem_rd_req_valid(mem_req_valid), .to_mem_rd_req_addr(mem_req_addr),
        .from_mem_rd_req_ready(mem_req_ready),
        .from_mem_rd_rsp_valid(mem_rsp_valid), .from_mem_rd_rsp_data(mem_rsp_data),
        .from_mem_rd_rsp_last(mem_rsp_last), .to_mem_rd_rsp_ready(mem_rsp_ready),
        .burst_overrun(overrun)
    );

    mem_rd_arbiter #(.RR_EN(0), .MAX_BEATS(8)) u_fp (
        .clk(clk), .rst(rst),
        .from_ic_rd_req_valid(ic_valid), .from_ic_rd_req_addr(ic_addr),
        .to_ic_rd_req_ready(fp_ic_req_ready), .to_ic_rd_rsp_valid(fp_ic_rsp_valid),
        .to_ic_rd_rsp_data(fp_ic_rsp_data), .to_ic_rd_rsp_last(fp_ic_rsp_last),
        .from_ic_rd_rsp_ready(ic_rsp_ready),
        .from_dc_rd_req_valid(dc_valid), .from_dc_rd_req_addr(dc_addr),
        .to_dc_rd_req_ready(fp_dc_req_ready), .to_dc_rd_rsp_valid(fp_dc_rsp_valid),
        .to_dc_rd_rsp_data(fp_dc_rsp_data), .to_dc_rd_rsp_last(fp_dc_rsp_last),
        .from_dc_rd_rsp_ready(dc_rsp_ready),
        .to_mem_rd_req_valid(fp_mem_req_valid), .to_mem_rd_req_addr(fp_mem_req_addr),
        .from_mem_rd_req_ready(mem_req_ready),
        .from_mem_rd_rsp_valid(mem_rsp_valid), .from_mem_rd_rsp_data(mem_rsp_data),
        .from_mem_rd_rsp_last(mem_rsp_last), .to_mem_rd_rsp_ready(fp_mem_rsp_ready),
        .burst_overrun(fp_overrun)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
    } req_t;

    beat_t exp_q[$];
    req_t  req_q[$];
    int    total = 0;
    int    bad = 0;
    logic  exp_ovr = 1'b0;
    int    fp_dc_rdy_cnt = 0;
    int    fp_ic_beats = 0;
    int    fp_ic_acc = 0;

    function automatic void check(string nm, logic [63:0] act,
                                  logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    // Scoreboard monitor for the round-robin instance
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check("req_addr", mem_req_addr, r.addr);
                    check("req_ready_route", {ic_req_ready, dc_req_ready},
                          {~r.id, r.id});
                end
            end
            if (ic_rsp_valid)
                check("rsp_ready_mirror", mem_rsp_ready, ic_rsp_ready);
            if ((ic_rsp_valid && ic_rsp_ready)
                || (dc_rsp_valid && dc_rsp_ready)) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    beat_t e, a;
                    e = exp_q.pop_front();
                    a.id   = dc_rsp_valid;
                    a.data = dc_rsp_valid ? dc_rsp_data : ic_rsp_data;
                    a.last = dc_rsp_valid ? dc_rsp_last : ic_rsp_last;
                    check("beat", a, e);
                end
            end
        end
    end

    // Observation counters for the fixed-priority instance
    always @(negedge clk) begin
        if (fp_dc_req_ready) fp_dc_rdy_cnt++;
        if (fp_ic_rsp_valid && ic_rsp_ready) fp_ic_beats++;
        if (fp_mem_req_valid && mem_req_ready && fp_ic_req_ready)
            fp_ic_acc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_valid && n < 50);
        tick();
    endtask

    task automatic mem_serve(input logic id, input logic [31:0] addr,
                             input logic [31:0] dbase, input int nbeats,
                             input bit give_last, input int rdy_dly,
                             input bit bp, input bit keep);
        int   n;
        logic ic_acc, dc_acc, hs, lst;
        req_q.push_back('{id: id, addr: addr});
        n = 0;
        while (!mem_req_valid && n < 50) begin
            tick();
            n++;
        end
        check("req_timeout", n < 50, 1);
        repeat (rdy_dly) tick();
        mem_req_ready = 1'b1;
        @(negedge clk);
        ic_acc = ic_req_ready;
        dc_acc = dc_req_ready;
        tick();
        mem_req_ready = 1'b0;
        if (!keep) begin
            if (ic_acc) ic_valid = 1'b0;
            if (dc_acc) dc_valid = 1'b0;
        end
        for (int b = 0; b < nbeats; b++) begin
            lst = give_last && (b == nbeats - 1);
            exp_q.push_back('{id: id, data: dbase + b, last: lst});
        end
        ic_rsp_ready = 1'b1;
        dc_rsp_ready = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            lst = give_last && (b == nbeats - 1);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dbase + b;
            mem_rsp_last  = lst;
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 50) begin
                @(negedge clk);
                hs = mem_rsp_ready;
                tick();
                n++;
                if (bp) begin
                    ic_rsp_ready = ~ic_rsp_ready;
                    dc_rsp_ready = ~dc_rsp_ready;
                end
            end
            check("beat_timeout", hs, 1);
            if (!lst && b == 7) exp_ovr = 1'b1;
            check("overrun", overrun, exp_ovr);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_last  = 1'b0;
        ic_rsp_ready  = 1'b1;
        dc_rsp_ready  = 1'b1;
    endtask

    initial begin
        int n;
        int s_rdy, s_beats, s_acc;
        do_reset();
        @(negedge clk);
        check("rst_outs", {ic_req_ready, ic_rsp_valid, ic_rsp_data,
              ic_rsp_last, dc_req_ready, dc_rsp_valid, dc_rsp_data,
              dc_rsp_last, mem_req_valid, mem_req_addr, mem_rsp_ready,
              overrun} != '0, 0);
        tick();

        // I-cache only, 8 beats
        ic_addr  = 32'h0000_1000;
        ic_valid = 1'b1;
        wait_req(n);
        check("req_latency", n, 2);
        mem_serve(0, 32'h1000, 32'hA0, 8, 1, 2, 0, 0);
        @(negedge clk);
        check("idle_after_last", {mem_req_valid, mem_rsp_ready}, 0);
        tick();

        // Both valid after reset, round robin
        do_reset();
        ic_addr  = 32'h100;
        dc_addr  = 32'h200;
        ic_valid = 1'b1;
        dc_valid = 1'b1;
        mem_serve(0, 32'h100, 32'h50, 4, 1, 0, 0, 0);
        wait_req(n);
        check("dc_req_gap", n, 2);
        mem_serve(1, 32'h200, 32'h60, 4, 1, 0, 0, 0);
        tick();
        ic_valid = 1'b1;
        dc_valid = 1'b1;
        mem_serve(0, 32'h100, 32'h70, 1, 1, 0, 0, 0);
        mem_serve(1, 32'h200, 32'h78, 1, 1, 0, 0, 0);
        tick();

        // Overrun: 9 beats with last on the 9th
        ic_addr  = 32'h3000;
        ic_valid = 1'b1;
        mem_serve(0, 32'h3000, 32'hC0, 9, 1, 1, 0, 0);
        @(negedge clk);
        check("idle_after_overrun", {mem_req_valid, mem_rsp_ready}, 0);
        check("overrun_sticky", overrun, 1);
        tick();

        // Reset in RESP after 3 beats
        ic_addr  = 32'h7000;
        ic_valid = 1'b1;
        mem_serve(0, 32'h7000, 32'hE0, 3, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        check("rst_mid_outs", {ic_req_ready, ic_rsp_valid, dc_rsp_valid,
              mem_req_valid, mem_req_addr, mem_rsp_ready}, 0);
        check("rst_mid_overrun", overrun, 0);
        rst = 1'b0;
        exp_ovr = 1'b0;
        dc_addr  = 32'h2000;
        dc_valid = 1'b1;
        mem_serve(1, 32'h2000, 32'hD0, 8, 1, 0, 0, 0);
        tick();

        // Backpressure on I-cache rsp_ready
        ic_addr  = 32'h4000;
        ic_valid = 1'b1;
        mem_serve(0, 32'h4000, 32'hB0, 8, 1, 0, 1, 0);
        tick();

        // Both valid continuously for 3 bursts
        do_reset();
        s_rdy   = fp_dc_rdy_cnt;
        s_beats = fp_ic_beats;
        s_acc   = fp_ic_acc;
        ic_addr  = 32'h5000;
        dc_addr  = 32'h6000;
        ic_valid = 1'b1;
        dc_valid = 1'b1;
        mem_serve(0, 32'h5000, 32'h10, 8, 1, 0, 0, 1);
        mem_serve(1, 32'h6000, 32'h20, 8, 1, 0, 0, 1);
        mem_serve(0, 32'h5000, 32'h30, 8, 1, 0, 0, 1);
        ic_valid = 1'b0;
        dc_valid = 1'b0;
        repeat (3) tick();
        check("fp_dc_ready_never", fp_dc_rdy_cnt - s_rdy, 0);
        check("fp_ic_beats", fp_ic_beats - s_beats, 24);
        check("fp_ic_grants", fp_ic_acc - s_acc, 3);

        check("beats_left", exp_q.size(), 0);
        check("reqs_left", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
